// File: rtl/avg_sample_collector.sv
// Serial-to-parallel feeder for the eight-input pipelined averager: packs up to
// eight samples into a..h/num, holds them for the averager latency, then flags avg_valid.
module avg_sample_collector #(
  parameter int DATAW       = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [DATAW-1:0] a,
  output logic [DATAW-1:0] b,
  output logic [DATAW-1:0] c,
  output logic [DATAW-1:0] d,
  output logic [DATAW-1:0] e,
  output logic [DATAW-1:0] f,
  output logic [DATAW-1:0] g,
  output logic [DATAW-1:0] h,
  output logic [DATAW-1:0] num,
  output logic             out_valid,
  output logic             avg_valid
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [3:0]       count_inc;
  logic [DATAW-1:0] slot_q [8];
  logic [DATAW-1:0] slot_d [8];
  logic [DATAW-1:0] num_q, num_d;
  logic [7:0]       hold_q, hold_d;
  logic             avg_valid_q, avg_valid_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    slot_d      = slot_q;
    num_d       = num_q;
    hold_d      = hold_q;
    avg_valid_d = 1'b0;
    count_inc   = {1'b0, count_q} + 4'd1;
    in_ready    = (state_q == FILL);
    out_valid   = (state_q == HOLD);

    case (state_q)
      FILL: begin
        if (in_valid) begin
          // The sample lands first; a same-cycle flush then closes the group around it.
          slot_d[count_q] = in_data;
          if (count_q == 3'd7 || flush) begin
            num_d   = DATAW'(count_inc);
            count_d = 3'd0;
            hold_d  = 8'd0;
            state_d = HOLD;
          end else begin
            count_d = count_inc[2:0];
          end
        end else if (flush && count_q != 3'd0) begin
          num_d   = DATAW'(count_q);
          count_d = 3'd0;
          hold_d  = 8'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d     = FILL;
          hold_d      = 8'd0;
          avg_valid_d = 1'b1;
          for (int i = 0; i < 8; i++) slot_d[i] = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= FILL;
      count_q     <= 3'd0;
      num_q       <= '0;
      hold_q      <= 8'd0;
      avg_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      num_q       <= num_d;
      hold_q      <= hold_d;
      avg_valid_q <= avg_valid_d;
      slot_q      <= slot_d;
    end
  end

  assign a         = slot_q[0];
  assign b         = slot_q[1];
  assign c         = slot_q[2];
  assign d         = slot_q[3];
  assign e         = slot_q[4];
  assign f         = slot_q[5];
  assign g         = slot_q[6];
  assign h         = slot_q[7];
  assign num       = num_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: tb/tb_avg_sample_collector.sv
// Bench for avg_sample_collector: directed scenarios plus random traffic, every
// cycle compared against a queue-based model of the collector's group behaviour.
module tb_avg_sample_collector;

  localparam int DATAW = 16;
  localparam int HOLD  = 8;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [DATAW-1:0] a, b, c, d, e, f, g, h;
  logic [DATAW-1:0] num;
  logic             out_valid;
  logic             avg_valid;

  avg_sample_collector #(.DATAW(DATAW), .HOLD_CYCLES(HOLD)) dut (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .num(num), .out_valid(out_valid), .avg_valid(avg_valid)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: samples gathered so far, the frozen group, and hold time left.
  logic [DATAW-1:0] grp [$];
  logic [DATAW-1:0] ops [8];
  bit               holding;
  int               hold_left;
  int               m_num;
  bit               m_avg;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    grp.delete();
    for (int i = 0; i < 8; i++) ops[i] = '0;
    holding   = 1'b0;
    hold_left = 0;
    m_num     = 0;
    m_avg     = 1'b0;
  endtask

  task automatic model_update(input logic r, input logic v, input logic [DATAW-1:0] dat,
                              input logic fl);
    if (!r) begin
      model_reset();
    end else if (holding) begin
      m_avg = 1'b0;
      hold_left--;
      if (hold_left == 0) begin
        holding = 1'b0;
        m_avg   = 1'b1;
        for (int i = 0; i < 8; i++) ops[i] = '0;
      end
    end else begin
      m_avg = 1'b0;
      if (v) grp.push_back(dat);
      if (grp.size() == 8 || (fl && grp.size() > 0)) begin
        for (int i = 0; i < 8; i++) ops[i] = (i < grp.size()) ? grp[i] : '0;
        m_num     = grp.size();
        grp.delete();
        holding   = 1'b1;
        hold_left = HOLD;
      end
    end
  endtask

  function automatic logic [127:0] exp_slots();
    logic [127:0] v;
    for (int i = 0; i < 8; i++)
      v[127-16*i -: 16] = holding ? ops[i] : ((i < grp.size()) ? grp[i] : 16'h0);
    return v;
  endfunction

  task automatic step(input logic r, input logic v, input logic [DATAW-1:0] dat, input logic fl);
    Rst      = r;
    in_valid = v;
    in_data  = dat;
    flush    = fl;
    @(negedge Clk);
    check("in_ready",  in_ready,  !holding);
    check("out_valid", out_valid, holding);
    check("avg_valid", avg_valid, m_avg);
    check("num",       num,       m_num);
    check("slots",     {a, b, c, d, e, f, g, h}, exp_slots());
    @(posedge Clk);
    model_update(r, v, dat, fl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int sum;
    Rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    repeat (2) @(posedge Clk);
    model_reset();
    #1;
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b1);

    // Full group 1..8
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 16'(i), 1'b0);
    check("full_a", a, 16'd1);
    check("full_h", h, 16'd8);
    check("full_num", num, 16'd8);
    sum = int'(a) + int'(b) + int'(c) + int'(d) + int'(e) + int'(f) + int'(g) + int'(h);
    check("full_avg", 32'(sum / int'(num)), 32'd4);
    idle(HOLD + 2);

    // Partial flush
    step(1'b1, 1'b1, 16'd10, 1'b0);
    step(1'b1, 1'b1, 16'd20, 1'b0);
    step(1'b1, 1'b1, 16'd30, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("part_abc", {a, b, c}, {16'd10, 16'd20, 16'd30});
    check("part_dh", {d, e, f, g, h}, 80'h0);
    check("part_num", num, 16'd3);
    sum = int'(a) + int'(b) + int'(c);
    check("part_avg", 32'(sum / int'(num)), 32'd20);
    idle(HOLD + 2);

    // Flush together with an accept
    step(1'b1, 1'b1, 16'd5, 1'b0);
    step(1'b1, 1'b1, 16'd7, 1'b0);
    step(1'b1, 1'b1, 16'd9, 1'b1);
    check("fa_abc", {a, b, c}, {16'd5, 16'd7, 16'd9});
    check("fa_num", num, 16'd3);
    idle(HOLD + 2);

    // Empty flush after reset
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    check("ef_num", num, 16'd0);
    check("ef_ov", out_valid, 1'b0);
    check("ef_rdy", in_ready, 1'b1);

    // Backpressure: sample held through HOLD, taken in the avg_valid cycle
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    for (int i = 0; i < HOLD + 1; i++) step(1'b1, 1'b1, 16'hABCD, 1'b0);
    check("bp_a", a, 16'hABCD);
    check("bp_rdy", in_ready, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    idle(HOLD + 2);

    // Reset on hold cycle 3
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    idle(2);
    step(1'b0, 1'b0, '0, 1'b0);
    check("rh_slots", {a, b, c, d, e, f, g, h}, 128'h0);
    check("rh_num", num, 16'd0);
    check("rh_ov", out_valid, 1'b0);
    check("rh_rdy", in_ready, 1'b1);
    idle(HOLD + 4);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 6),
           16'($urandom_range(0, 65535)), ($urandom_range(0, 9) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
